screen_controller: RTL and testbench



---
 rtl/screen_controller.sv | 201 ++++++++++++++++++++
 tb/tb_screen_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_controller.sv
// screen_controller: frame-aligned sequencer selecting between the start, main
// and end screens. It holds the main screen in reset outside play and latches
// the final score when play ends.
// Optional build macro SCREEN_FADE_EN: after every screen change, the first
// half of a FADE_FRAMES-long fade shows the new source at half intensity.
module screen_controller #(
   parameter logic [3:0]  WIN_SCORE   = 4'd9,
   parameter int unsigned HOLD_FRAMES = 60,
   parameter int unsigned FRAME_CNT_W = 8,
   parameter int unsigned FADE_FRAMES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       key5IsPressed,
   input  logic [3:0] life,
   input  logic [3:0] score,
   input  logic [7:0] RGB_screen_main,
   input  logic [7:0] RGB_screen_start,
   input  logic [7:0] RGB_screen_end,
   output logic [7:0] RGB_out,
   output logic       main_resetN,
   output logic [1:0] screen,
   output logic [3:0] final_score
);

   typedef enum logic [1:0] {
      ST_START     = 2'd0,
      ST_MAIN      = 2'd1,
      ST_GAME_OVER = 2'd2,
      ST_WIN       = 2'd3
   } state_t;

   localparam logic [FRAME_CNT_W-1:0] HOLD_CNT = FRAME_CNT_W'(HOLD_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] CNT_MAX  = '1;

   state_t                 state_q, state_d;
   state_t                 pend_state_q, pend_state_d;
   logic                   pend_valid_q, pend_valid_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   key_prev_q, key_prev_d;
   logic                   main_resetn_q, main_resetn_d;
   logic [1:0]             screen_q, screen_d;
   logic [3:0]             final_score_q, final_score_d;
   logic [7:0]             rgb_q, rgb_d;

   logic                   key_rise;
   logic                   fade_busy;
   logic                   req_valid;
   state_t                 req_state;
   logic                   apply;
   logic [FRAME_CNT_W-1:0] cnt_limit;
   logic [7:0]             rgb_src;

`ifdef SCREEN_FADE_EN
   localparam logic [FRAME_CNT_W-1:0] FADE_CNT  = FRAME_CNT_W'(FADE_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] FADE_HALF = FRAME_CNT_W'(FADE_FRAMES / 2);

   logic [FRAME_CNT_W-1:0] fade_cnt_q, fade_cnt_d;
`endif

   // Key edge detection and fade activity flag
   always_comb begin
      key_rise  = key5IsPressed & ~key_prev_q;
`ifdef SCREEN_FADE_EN
      fade_busy = (fade_cnt_q < FADE_CNT);
`else
      fade_busy = 1'b0;
`endif
   end

   // Per-state screen change request; GAME_OVER outranks WIN
   always_comb begin
      req_valid = 1'b0;
      req_state = ST_START;
      case (state_q)
         ST_START: begin
            if (key_rise && !fade_busy) begin
               req_valid = 1'b1;
               req_state = ST_MAIN;
            end
         end
         ST_MAIN: begin
            if (main_resetn_q) begin
               if (life == 4'd0) begin
                  req_valid = 1'b1;
                  req_state = ST_GAME_OVER;
               end else if (score >= WIN_SCORE) begin
                  req_valid = 1'b1;
                  req_state = ST_WIN;
               end
            end
         end
         default: begin
            if (key_rise && (frame_cnt_q == HOLD_CNT)) begin
               req_valid = 1'b1;
               req_state = ST_START;
            end
         end
      endcase
   end

   // Pending request, frame-aligned state change, frame counter and score latch
   always_comb begin
      state_d       = state_q;
      pend_state_d  = pend_state_q;
      pend_valid_d  = pend_valid_q;
      frame_cnt_d   = frame_cnt_q;
      final_score_d = final_score_q;
      key_prev_d    = key5IsPressed;

      // apply uses the registered pending flag, so a request raised in a
      // startOfFrame cycle waits for the following frame start
      apply     = startOfFrame & pend_valid_q;
      cnt_limit = ((state_q == ST_GAME_OVER) || (state_q == ST_WIN)) ? HOLD_CNT : CNT_MAX;

      if (apply) begin
         state_d      = pend_state_q;
         pend_valid_d = 1'b0;
         frame_cnt_d  = '0;
         if (state_q == ST_MAIN) begin
            final_score_d = score;
         end
      end else begin
         if (req_valid) begin
            pend_valid_d = 1'b1;
            pend_state_d = req_state;
         end
         if (startOfFrame && (frame_cnt_q != cnt_limit)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end

      main_resetn_d = (state_d == ST_MAIN) && (frame_cnt_d != '0);
      screen_d      = state_d;
   end

   // Pixel source select, optionally dimmed during the first half of a fade
   always_comb begin
      case (state_q)
         ST_START: rgb_src = RGB_screen_start;
         ST_MAIN:  rgb_src = RGB_screen_main;
         default:  rgb_src = RGB_screen_end;
      endcase
      rgb_d = rgb_src;
`ifdef SCREEN_FADE_EN
      if (fade_cnt_q < FADE_HALF) begin
         rgb_d = {1'b0, rgb_src[7:6], 1'b0, rgb_src[4:3], 1'b0, rgb_src[1]};
      end
`endif
   end

`ifdef SCREEN_FADE_EN
   // Fade counter restarts on every state change and stops at FADE_FRAMES
   always_comb begin
      fade_cnt_d = fade_cnt_q;
      if (state_d != state_q) begin
         fade_cnt_d = '0;
      end else if (startOfFrame && (fade_cnt_q < FADE_CNT)) begin
         fade_cnt_d = fade_cnt_q + 1'b1;
      end
   end
`endif

   // All state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_START;
         pend_state_q  <= ST_START;
         pend_valid_q  <= 1'b0;
         frame_cnt_q   <= '0;
         key_prev_q    <= 1'b0;
         main_resetn_q <= 1'b0;
         screen_q      <= '0;
         final_score_q <= '0;
         rgb_q         <= '0;
`ifdef SCREEN_FADE_EN
         fade_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         pend_state_q  <= pend_state_d;
         pend_valid_q  <= pend_valid_d;
         frame_cnt_q   <= frame_cnt_d;
         key_prev_q    <= key_prev_d;
         main_resetn_q <= main_resetn_d;
         screen_q      <= screen_d;
         final_score_q <= final_score_d;
         rgb_q         <= rgb_d;
`ifdef SCREEN_FADE_EN
         fade_cnt_q    <= fade_cnt_d;
`endif
      end
   end

   assign RGB_out     = rgb_q;
   assign main_resetN = main_resetn_q;
   assign screen      = screen_q;
   assign final_score = final_score_q;

endmodule

// File: tb/tb_screen_controller.sv
// Testbench for screen_controller: scenario tasks with a pixel scoreboard.
module tb_screen_controller;

   localparam int FL = 6;  // cycles per frame
`ifdef SCREEN_FADE_EN
   localparam int SETTLE = 16;
`else
   localparam int SETTLE = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       startOfFrame = 1'b0;
   logic       key5IsPressed = 1'b0;
   logic [3:0] life = 4'd3;
   logic [3:0] score = 4'd0;
   logic [7:0] RGB_screen_main = '0;
   logic [7:0] RGB_screen_start = '0;
   logic [7:0] RGB_screen_end = '0;
   logic [7:0] RGB_out;
   logic       main_resetN;
   logic [1:0] screen;
   logic [3:0] final_score;

   int         n_checks = 0;
   int         n_fails = 0;
   logic [7:0] exp_q[$];
   logic [1:0] exp_scr = 2'd0;
   bit         hold_main_ff = 1'b0;

   screen_controller #(
      .WIN_SCORE  (4'd9),
      .HOLD_FRAMES(60),
      .FRAME_CNT_W(8),
      .FADE_FRAMES(16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .startOfFrame    (startOfFrame),
      .key5IsPressed   (key5IsPressed),
      .life            (life),
      .score           (score),
      .RGB_screen_main (RGB_screen_main),
      .RGB_screen_start(RGB_screen_start),
      .RGB_screen_end  (RGB_screen_end),
      .RGB_out         (RGB_out),
      .main_resetN     (main_resetN),
      .screen          (screen),
      .final_score     (final_score)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   // One clock: drive at negedge, push expected pixel, compare after posedge
   task automatic tick(input logic sof);
      logic [7:0] want;
      @(negedge clk);
      startOfFrame     = sof;
      RGB_screen_main  = hold_main_ff ? 8'hFF : 8'($urandom);
      RGB_screen_start = 8'($urandom);
      RGB_screen_end   = 8'($urandom);
`ifndef SCREEN_FADE_EN
      if (reset) exp_q.push_back(8'h00);
      else begin
         case (exp_scr)
            2'd0:    exp_q.push_back(RGB_screen_start);
            2'd1:    exp_q.push_back(RGB_screen_main);
            default: exp_q.push_back(RGB_screen_end);
         endcase
      end
`endif
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         n_checks++;
         if (RGB_out !== want) begin
            n_fails++;
            $display("FAIL rgb_out: got %h expected %h (screen %0d)", RGB_out, want, exp_scr);
         end
      end
   endtask

   task automatic frame_idle(input int n);
      for (int f = 0; f < n; f++) begin
         tick(1'b1);
         repeat (FL - 1) tick(1'b0);
      end
   endtask

   task automatic enter_main();
      frame_idle(SETTLE);
      tick(1'b1);
      tick(1'b0);
      key5IsPressed = 1'b1;
      tick(1'b0);
      key5IsPressed = 1'b0;
      repeat (3) tick(1'b0);
      tick(1'b1);
      exp_scr = 2'd1;
      n_checks++;
      if (screen !== 2'd1) begin
         n_fails++; $display("FAIL enter_main screen: got %0d expected 1", screen);
      end
      repeat (FL - 1) tick(1'b0);
      tick(1'b1);
      n_checks++;
      if (main_resetN !== 1'b1) begin
         n_fails++; $display("FAIL enter_main main_resetN: got %b expected 1", main_resetN);
      end
      repeat (FL - 1) tick(1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      exp_scr = 2'd0;
      tick(1'b0);
      tick(1'b0);
      n_checks++;
      if (screen !== 2'd0) begin n_fails++; $display("FAIL reset screen: got %0d expected 0", screen); end
      n_checks++;
      if (main_resetN !== 1'b0) begin n_fails++; $display("FAIL reset main_resetN: got %b expected 0", main_resetN); end
      n_checks++;
      if (final_score !== 4'd0) begin n_fails++; $display("FAIL reset final_score: got %0d expected 0", final_score); end
      n_checks++;
      if (RGB_out !== 8'h00) begin n_fails++; $display("FAIL reset rgb_out: got %h expected 00", RGB_out); end
      reset = 1'b0;
      for (int f = 0; f < 3; f++) begin
         tick(1'b1);
         n_checks++;
         if (screen !== 2'd0) begin n_fails++; $display("FAIL idle_start screen: got %0d expected 0", screen); end
         n_checks++;
         if (main_resetN !== 1'b0) begin n_fails++; $display("FAIL idle_start main_resetN: got %b expected 0", main_resetN); end
         repeat (FL - 1) tick(1'b0);
      end
   endtask

   task automatic test_start_to_main();
      frame_idle(SETTLE);
      tick(1'b1);
      tick(1'b0);
      key5IsPressed = 1'b1;
      repeat (4) tick(1'b0);
      n_checks++;
      if (screen !== 2'd0) begin n_fails++; $display("FAIL early_switch screen: got %0d expected 0", screen); end
      tick(1'b1);
      exp_scr = 2'd1;
      n_checks++;
      if (screen !== 2'd1) begin n_fails++; $display("FAIL start_to_main screen: got %0d expected 1", screen); end
      n_checks++;
      if (main_resetN !== 1'b0) begin n_fails++; $display("FAIL main_first_frame main_resetN: got %b expected 0", main_resetN); end
      repeat (FL - 1) tick(1'b0);
      n_checks++;
      if (main_resetN !== 1'b0) begin n_fails++; $display("FAIL main_first_frame_end main_resetN: got %b expected 0", main_resetN); end
      tick(1'b1);
      n_checks++;
      if (main_resetN !== 1'b1) begin n_fails++; $display("FAIL main_second_frame main_resetN: got %b expected 1", main_resetN); end
      repeat (FL - 1) tick(1'b0);
      for (int f = 0; f < 10; f++) begin
         tick(1'b1);
         n_checks++;
         if (screen !== 2'd1 || main_resetN !== 1'b1) begin
            n_fails++;
            $display("FAIL key_held frame %0d: got screen %0d resetN %b expected screen 1 resetN 1", f, screen, main_resetN);
         end
         repeat (FL - 1) tick(1'b0);
      end
      key5IsPressed = 1'b0;
   endtask

   task automatic test_game_over();
      tick(1'b1);
      tick(1'b0);
      life  = 4'd0;
      score = 4'd9;
      repeat (4) tick(1'b0);
      n_checks++;
      if (screen !== 2'd1) begin n_fails++; $display("FAIL game_over_early screen: got %0d expected 1", screen); end
      tick(1'b1);
      exp_scr = 2'd2;
      n_checks++;
      if (screen !== 2'd2) begin n_fails++; $display("FAIL game_over screen: got %0d expected 2", screen); end
      n_checks++;
      if (final_score !== 4'd9) begin n_fails++; $display("FAIL game_over final_score: got %0d expected 9", final_score); end
      n_checks++;
      if (main_resetN !== 1'b0) begin n_fails++; $display("FAIL game_over main_resetN: got %b expected 0", main_resetN); end
      life  = 4'd3;
      score = 4'd0;
      repeat (FL - 1) tick(1'b0);
      n_checks++;
      if (final_score !== 4'd9) begin n_fails++; $display("FAIL final_score_hold: got %0d expected 9", final_score); end
      reset = 1'b1;
      tick(1'b0);
      reset = 1'b0;
      exp_scr = 2'd0;
      repeat (FL - 1) tick(1'b0);
   endtask

   task automatic test_win();
      life  = 4'd2;
      score = 4'd0;
      enter_main();
      tick(1'b1);
      tick(1'b0);
      score = 4'd9;
      repeat (4) tick(1'b0);
      tick(1'b1);
      exp_scr = 2'd3;
      n_checks++;
      if (screen !== 2'd3) begin n_fails++; $display("FAIL win screen: got %0d expected 3", screen); end
      n_checks++;
      if (final_score !== 4'd9) begin n_fails++; $display("FAIL win final_score: got %0d expected 9", final_score); end
      n_checks++;
      if (main_resetN !== 1'b0) begin n_fails++; $display("FAIL win main_resetN: got %b expected 0", main_resetN); end
      score = 4'd0;
      repeat (FL - 1) tick(1'b0);
      for (int k = 1; k <= 61; k++) begin
         tick(1'b1);
         n_checks++;
         if (screen !== 2'd3) begin n_fails++; $display("FAIL win_hold frame %0d screen: got %0d expected 3", k, screen); end
         if (k == 30) begin
            tick(1'b0); key5IsPressed = 1'b1;
            tick(1'b0); key5IsPressed = 1'b0;
            repeat (3) tick(1'b0);
         end else if (k == 59) begin
            tick(1'b0); key5IsPressed = 1'b1;
            repeat (4) tick(1'b0);
         end else if (k == 61) begin
            tick(1'b0); key5IsPressed = 1'b0;
            tick(1'b0); key5IsPressed = 1'b1;
            tick(1'b0); key5IsPressed = 1'b0;
            repeat (2) tick(1'b0);
         end else begin
            repeat (FL - 1) tick(1'b0);
         end
      end
      tick(1'b1);
      exp_scr = 2'd0;
      n_checks++;
      if (screen !== 2'd0) begin n_fails++; $display("FAIL win_to_start screen: got %0d expected 0", screen); end
      n_checks++;
      if (main_resetN !== 1'b0) begin n_fails++; $display("FAIL win_to_start main_resetN: got %b expected 0", main_resetN); end
      n_checks++;
      if (final_score !== 4'd9) begin n_fails++; $display("FAIL win_to_start final_score: got %0d expected 9", final_score); end
      repeat (FL - 1) tick(1'b0);
   endtask

   task automatic test_reset_mid();
      life  = 4'd2;
      score = 4'd0;
      enter_main();
      tick(1'b1);
      tick(1'b0);
      score = 4'd9;
      repeat (4) tick(1'b0);
      tick(1'b1);
      exp_scr = 2'd3;
      n_checks++;
      if (screen !== 2'd3 || final_score !== 4'd9) begin
         n_fails++; $display("FAIL pre_reset win: got screen %0d score %0d expected screen 3 score 9", screen, final_score);
      end
      score = 4'd0;
      repeat (2) tick(1'b0);
      reset = 1'b1;
      tick(1'b0);
      reset = 1'b0;
      exp_scr = 2'd0;
      n_checks++;
      if (screen !== 2'd0) begin n_fails++; $display("FAIL mid_reset screen: got %0d expected 0", screen); end
      n_checks++;
      if (final_score !== 4'd0) begin n_fails++; $display("FAIL mid_reset final_score: got %0d expected 0", final_score); end
      n_checks++;
      if (main_resetN !== 1'b0) begin n_fails++; $display("FAIL mid_reset main_resetN: got %b expected 0", main_resetN); end
      n_checks++;
      if (RGB_out !== 8'h00) begin n_fails++; $display("FAIL mid_reset rgb_out: got %h expected 00", RGB_out); end
      repeat (2) tick(1'b0);
   endtask

   task automatic test_key_on_sof();
      frame_idle(SETTLE);
      tick(1'b1);
      repeat (FL - 1) tick(1'b0);
      key5IsPressed = 1'b1;
      tick(1'b1);
      key5IsPressed = 1'b0;
      n_checks++;
      if (screen !== 2'd0) begin n_fails++; $display("FAIL key_on_sof same_frame screen: got %0d expected 0", screen); end
      repeat (FL - 1) tick(1'b0);
      tick(1'b1);
      exp_scr = 2'd1;
      n_checks++;
      if (screen !== 2'd1) begin n_fails++; $display("FAIL key_on_sof next_frame screen: got %0d expected 1", screen); end
      repeat (FL - 1) tick(1'b0);
   endtask

`ifdef SCREEN_FADE_EN
   task automatic test_fade();
      reset = 1'b1;
      tick(1'b0);
      reset = 1'b0;
      exp_scr = 2'd0;
      life  = 4'd2;
      score = 4'd0;
      hold_main_ff = 1'b1;
      frame_idle(SETTLE);
      tick(1'b1);
      tick(1'b0);
      key5IsPressed = 1'b1;
      tick(1'b0);
      key5IsPressed = 1'b0;
      repeat (3) tick(1'b0);
      tick(1'b1);
      exp_scr = 2'd1;
      for (int f = 0; f < 10; f++) begin
         repeat (3) tick(1'b0);
         n_checks++;
         if (RGB_out !== ((f < 8) ? 8'h6D : 8'hFF)) begin
            n_fails++;
            $display("FAIL fade frame %0d rgb_out: got %h expected %h", f, RGB_out, (f < 8) ? 8'h6D : 8'hFF);
         end
         repeat (2) tick(1'b0);
         tick(1'b1);
      end
      hold_main_ff = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_start_to_main();
      test_game_over();
      test_win();
      test_reset_mid();
      test_key_on_sof();
`ifdef SCREEN_FADE_EN
      test_fade();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
